// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and forwarding controller for a 5-stage IF/ID/EX/MEM/WB core.
// A shadow pipeline of register tags (rs1, rs2, rd, regwrite, memread) is kept
// for the EX, MEM and WB stages. The ID-stage instruction is compared with it to
// produce stage stalls, the ID/EX bubble, the branch flush strobes and the EX
// operand forwarding selects.
//
// Parameters
//   RA_W    register address width (register 0 is hard-wired zero)
//   FWD_EN  1: forward EX/MEM and MEM/WB into EX, stall only on load-use
//           0: no forwarding, stall on any RAW against EX or MEM
//   CNT_W   width of the saturating performance counters
//
// Ports
//   clk, rst_n                  rising-edge clock, async active-low reset
//   id_valid                    instruction present in ID
//   id_rs1, id_rs2              ID source registers
//   id_use_rs1, id_use_rs2      ID actually reads rs1 / rs2
//   id_rd, id_regwrite          ID destination and its write enable
//   id_memread                  ID instruction is a load
//   mem_pcsrc                   taken branch resolved in MEM
//   mem_busy                    data memory not ready, freeze the whole pipe
//   pc_stall, if_id_stall       hold PC / hold IF/ID latch
//   id_ex_bubble                load a nop into ID/EX
//   flush_if_id/id_ex/ex_mem    clear the named pipeline latch
//   pipe_freeze                 hold every pipeline latch
//   fwd_a, fwd_b                EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   state                       00 RUN, 01 STALL, 10 WAIT_MEM (informational)
//   stall_cnt                   cycles with pc_stall=1 (saturating)
//   flush_cnt                   taken-branch flush events (saturating)
//
// Priority of the control outputs: memory wait > branch flush > hazard stall.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int RA_W   = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             mem_pcsrc,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_bubble,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic            regwrite;
        logic            memread;
    } tag_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_STALL    = 2'b01,
        ST_WAIT_MEM = 2'b10
    } state_e;

    // Low from reset until the first clock after release: keeps every control
    // output at zero during that window even if mem_busy/mem_pcsrc are high.
    logic   active_q;

    tag_t   ex_q, ex_d;
    tag_t   mem_q, mem_d;
    tag_t   wb_q, wb_d;
    state_e state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic match_ex, match_mem, hazard, busy, branch;

    // RAW match of the ID instruction against one shadow stage; rd=0 never matches.
    function automatic logic raw_match(input tag_t x, input logic vld,
                                       input logic u1, input logic u2,
                                       input logic [RA_W-1:0] r1,
                                       input logic [RA_W-1:0] r2);
        return vld && x.regwrite && (x.rd != '0) &&
               ((u1 && (r1 == x.rd)) || (u2 && (r2 == x.rd)));
    endfunction

    // EX/MEM wins over MEM/WB because it holds the younger value.
    function automatic logic [1:0] fwd_sel(input tag_t m, input tag_t w,
                                           input logic [RA_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (m.regwrite && (m.rd != '0) && (m.rd == src)) begin
            sel = 2'b10;
        end else if (w.regwrite && (w.rd != '0) && (w.rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Hazard detection and control outputs
    always_comb begin
        match_ex  = raw_match(ex_q,  id_valid, id_use_rs1, id_use_rs2, id_rs1, id_rs2);
        match_mem = raw_match(mem_q, id_valid, id_use_rs1, id_use_rs2, id_rs1, id_rs2);

        // With forwarding only a load in EX cannot be bypassed in time; without
        // it, EX and MEM producers must drain. WB is safe since the register file
        // writes in the first half-cycle.
        if (FWD_EN) begin
            hazard = active_q && match_ex && ex_q.memread;
        end else begin
            hazard = active_q && (match_ex || match_mem);
        end

        busy   = active_q && mem_busy;
        // A branch seen while busy is deferred until the first non-busy cycle.
        branch = active_q && mem_pcsrc && !mem_busy;

        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        pipe_freeze  = 1'b0;
        state_d      = ST_RUN;

        if (busy) begin
            pipe_freeze = 1'b1;
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
        end else if (branch) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (hazard) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end

        if (busy) begin
            state_d = ST_WAIT_MEM;
        end else if (hazard && !mem_pcsrc) begin
            state_d = ST_STALL;
        end

        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (FWD_EN) begin
            fwd_a = fwd_sel(mem_q, wb_q, ex_q.rs1);
            fwd_b = fwd_sel(mem_q, wb_q, ex_q.rs2);
        end
    end

    // Shadow pipeline advance and counters
    always_comb begin
        wb_d  = wb_q;
        mem_d = mem_q;
        ex_d  = ex_q;
        if (!pipe_freeze) begin
            wb_d  = mem_q;
            mem_d = flush_ex_mem ? '0 : ex_q;
            if (id_ex_bubble || flush_id_ex) begin
                ex_d = '0;
            end else begin
                ex_d.rs1      = id_rs1;
                ex_d.rs2      = id_rs2;
                ex_d.rd       = id_rd;
                ex_d.regwrite = id_regwrite && id_valid;
                ex_d.memread  = id_memread && id_valid;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (branch && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= 1'b0;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            active_q    <= 1'b1;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Two controllers share one stimulus stream: dut_f (forwarding, 16-bit
// counters) and dut_n (no forwarding, 4-bit counters so saturation is reached).
// Each cycle the driver applies inputs, asks the reference model what every
// output must be in that cycle and pushes the answer into a per-DUT queue. A
// monitor on the falling edge pops one entry per DUT and compares.
//
// The reference model treats the pipeline as three instruction records
// (EX, MEM, WB) and applies the hazard, forwarding, flush and wait rules
// directly to them.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int EW = 45;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_regwrite = 1'b0, id_memread = 1'b0, mem_pcsrc = 1'b0, mem_busy = 1'b0;

    logic        f_pcs, f_ifs, f_bub, f_fl1, f_fl2, f_fl3, f_frz;
    logic [1:0]  f_fa, f_fb, f_st;
    logic [15:0] f_scnt, f_fcnt;
    logic        n_pcs, n_ifs, n_bub, n_fl1, n_fl2, n_fl3, n_frz;
    logic [1:0]  n_fa, n_fb, n_st;
    logic [3:0]  n_scnt, n_fcnt;

    pipe_hazard_ctrl #(.RA_W(5), .FWD_EN(1'b1), .CNT_W(16)) dut_f (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .mem_pcsrc(mem_pcsrc),
        .mem_busy(mem_busy), .pc_stall(f_pcs), .if_id_stall(f_ifs), .id_ex_bubble(f_bub),
        .flush_if_id(f_fl1), .flush_id_ex(f_fl2), .flush_ex_mem(f_fl3), .pipe_freeze(f_frz),
        .fwd_a(f_fa), .fwd_b(f_fb), .state(f_st), .stall_cnt(f_scnt), .flush_cnt(f_fcnt)
    );

    pipe_hazard_ctrl #(.RA_W(5), .FWD_EN(1'b0), .CNT_W(4)) dut_n (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .mem_pcsrc(mem_pcsrc),
        .mem_busy(mem_busy), .pc_stall(n_pcs), .if_id_stall(n_ifs), .id_ex_bubble(n_bub),
        .flush_if_id(n_fl1), .flush_id_ex(n_fl2), .flush_ex_mem(n_fl3), .pipe_freeze(n_frz),
        .fwd_a(n_fa), .fwd_b(n_fb), .state(n_st), .stall_cnt(n_scnt), .flush_cnt(n_fcnt)
    );

    // ---------------- reference model ----------------
    instr_t      m_ex[2], m_mem[2], m_wb[2];
    int unsigned m_stalls[2], m_flushes[2];
    logic [1:0]  m_state[2];

    logic [EW-1:0] exp_f_q[$];
    logic [EW-1:0] exp_n_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    function automatic int unsigned cnt_max(input int k);
        return (k == 0) ? 32'd65535 : 32'd15;
    endfunction

    function automatic bit reads_from(input instr_t p);
        if (!id_valid || !p.rw || p.rd == 5'd0) return 1'b0;
        return (id_use_rs1 && id_rs1 == p.rd) || (id_use_rs2 && id_rs2 == p.rd);
    endfunction

    function automatic logic [1:0] src_of(input int k, input logic [4:0] r);
        if (m_mem[k].rw && m_mem[k].rd != 5'd0 && m_mem[k].rd == r) return 2'b10;
        if (m_wb[k].rw && m_wb[k].rd != 5'd0 && m_wb[k].rd == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
            m_stalls[k] = 0; m_flushes[k] = 0; m_state[k] = 2'b00;
        end
    endtask

    // Expected outputs for this cycle, then advance the model by one clock.
    task automatic model_step(input int k, output logic [EW-1:0] e);
        bit hz, stall, bub, fl, frz;
        logic [1:0] fa, fb;
        instr_t nxt;
        if (k == 0) hz = reads_from(m_ex[k]) && m_ex[k].mr;
        else        hz = reads_from(m_ex[k]) || reads_from(m_mem[k]);
        frz = mem_busy;
        fl  = mem_pcsrc && !mem_busy;
        stall = frz || (!fl && hz);
        bub   = !frz && !fl && hz;
        fa = (k == 0) ? src_of(k, m_ex[k].rs1) : 2'b00;
        fb = (k == 0) ? src_of(k, m_ex[k].rs2) : 2'b00;
        e = {stall, stall, bub, fl, fl, fl, frz, fa, fb, m_state[k],
             16'(m_stalls[k]), 16'(m_flushes[k])};

        if (!frz) begin
            m_wb[k]  = m_mem[k];
            m_mem[k] = fl ? instr_t'('0) : m_ex[k];
            nxt = '{rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                    rw: id_regwrite && id_valid, mr: id_memread && id_valid};
            m_ex[k] = (bub || fl) ? instr_t'('0) : nxt;
        end
        if (stall && m_stalls[k] < cnt_max(k)) m_stalls[k]++;
        if (fl && m_flushes[k] < cnt_max(k)) m_flushes[k]++;
        m_state[k] = frz ? 2'b10 : ((hz && !mem_pcsrc) ? 2'b01 : 2'b00);
    endtask

    task automatic push_expect();
        logic [EW-1:0] e;
        if (!rst_n) begin
            model_reset();
            exp_f_q.push_back('0);
            exp_n_q.push_back('0);
        end else begin
            model_step(0, e); exp_f_q.push_back(e);
            model_step(1, e); exp_n_q.push_back(e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_regwrite = 0; id_memread = 0; mem_pcsrc = 0; mem_busy = 0;
    endtask

    // One cycle: v, rs1, rs2, use1, use2, rd, regwrite, memread, pcsrc, busy
    task automatic tick(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic pc, input logic bz);
        @(posedge clk); #1;
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_regwrite = rw; id_memread = mr; mem_pcsrc = pc; mem_busy = bz;
        push_expect();
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Assert reset mid-cycle, hold it for n cycles, release with idle inputs.
    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst_n = 1'b0; set_idle(); push_expect();
        for (int i = 1; i < n; i++) begin
            @(posedge clk); #1; push_expect();
        end
        @(posedge clk); #1;
        rst_n = 1'b1; push_expect();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e, a;
        cyc++;
        if (exp_f_q.size() > 0) begin
            e = exp_f_q.pop_front();
            a = {f_pcs, f_ifs, f_bub, f_fl1, f_fl2, f_fl3, f_frz, f_fa, f_fb, f_st, f_scnt, f_fcnt};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL dut_f cyc=%0d got=%h exp=%h", cyc, a, e);
            end
        end
        if (exp_n_q.size() > 0) begin
            e = exp_n_q.pop_front();
            a = {n_pcs, n_ifs, n_bub, n_fl1, n_fl2, n_fl3, n_frz, n_fa, n_fb, n_st,
                 12'd0, n_scnt, 12'd0, n_fcnt};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL dut_n cyc=%0d got=%h exp=%h", cyc, a, e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        set_idle();
        // reset state checked while rst_n is low
        @(negedge clk); push_expect();
        do_reset(2);
        nop(1);

        // load-use: lw x5 ; add x6,x5,x1 held while stalled ; then drain
        tick(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        tick(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        tick(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        tick(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        nop(4);

        // ALU producer in MEM and WB feeding rs2 of the EX instruction
        tick(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
        tick(1, 1, 5, 1, 1, 7, 1, 0, 0, 0);
        tick(1, 1, 5, 1, 1, 7, 1, 0, 0, 0);
        tick(1, 5, 5, 1, 1, 8, 1, 0, 0, 0);
        nop(4);

        // back-to-back RAW: add x5 ; add x6,x5,x5 held
        tick(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
        nop(4);

        // taken branch while a load-use hazard is active
        tick(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        tick(1, 5, 1, 1, 1, 6, 1, 0, 1, 0);
        nop(4);

        // memory busy for 3 cycles with a pending branch, then branch fires
        tick(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(1, 5, 2, 1, 1, 6, 1, 0, 1, 1);
        tick(1, 5, 2, 1, 1, 6, 1, 0, 1, 0);
        nop(4);

        // reset in the middle of a stall
        tick(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        tick(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        do_reset(2);
        nop(2);

        // rd = 0 producers never stall or forward
        tick(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        tick(1, 0, 0, 1, 1, 6, 1, 0, 0, 0);
        tick(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        nop(4);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                tick($urandom_range(0, 99) < 80,
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     5'($urandom_range(0, 3)),
                     $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35,
                     $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10);
            end
        end
        nop(2);

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (exp_f_q.size() != 0 || exp_n_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending_f=%0d pending_n=%0d need=0", exp_f_q.size(), exp_n_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
